// File: rtl/mips32_pkg.sv
// Shared MIPS32 pipeline definitions: opcodes, instruction classes and the
// prefetch-queue entry layout used by the fetch front end.
package mips32_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {
    RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT
  } instr_type_e;

  localparam int FQ_ENTRY_W = 65;

  typedef struct packed {
    logic        taken;
    logic [31:0] npc;
    logic [31:0] ir;
  } fq_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular prefetch queue with flush; storage is not reset, only the
// pointers and occupancy count are.
module fetch_fifo #(
  parameter int WIDTH = 65,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign do_push = push && !flush;
  assign do_pop  = pop && !empty && !flush;
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/mips32_fetch_queue.sv
// MIPS32 instruction-fetch front end: credit-limited imem requests, in-order
// responses buffered with NPC, and branch redirects that flush stale work.
module mips32_fetch_queue
  import mips32_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic        clk1,
  input  logic        rst,
  input  logic        halted,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_ir,
  output logic [31:0] id_npc,
  output logic        id_taken,
  output logic        err
);

  localparam int CNT_W = $clog2(DEPTH+1);

  logic [31:0]      pc;
  logic [31:0]      resp_pc;
  logic [CNT_W-1:0] outstanding;
  logic [CNT_W-1:0] drop_cnt;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W:0]   credits_used;
  logic             first_flag;
  logic             q_empty;
  logic             issue;
  logic             resp;
  logic             accept;
  logic             pop;
  fq_entry_t        q_in;
  fq_entry_t        q_head;

  // Queued plus in-flight never exceeds DEPTH, so a response always has a slot.
  assign credits_used = {1'b0, q_count} + {1'b0, outstanding};
  assign imem_req     = !rst && !halted && !br_taken && (credits_used < (CNT_W+1)'(DEPTH));
  assign imem_addr    = pc;
  assign issue        = imem_req && imem_gnt;
  assign resp         = imem_rvalid && (outstanding != '0);
  assign accept       = resp && (drop_cnt == '0) && !br_taken;
  assign pop          = id_ready && !q_empty;

  assign q_in = '{taken: first_flag, npc: resp_pc + 32'd1, ir: imem_rdata};

  fetch_fifo #(.WIDTH(FQ_ENTRY_W), .DEPTH(DEPTH)) u_fifo (
    .clk       (clk1),
    .rst       (rst),
    .flush     (br_taken),
    .push      (accept),
    .push_data (q_in),
    .pop       (pop),
    .head      (q_head),
    .empty     (q_empty),
    .count     (q_count)
  );

  assign id_valid = !q_empty;
  assign id_ir    = q_empty ? 32'h0 : q_head.ir;
  assign id_npc   = q_empty ? 32'h0 : q_head.npc;
  assign id_taken = q_empty ? 1'b0  : q_head.taken;

  always_ff @(posedge clk1 or posedge rst) begin
    if (rst) begin
      pc          <= RESET_PC;
      resp_pc     <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
      first_flag  <= 1'b0;
      err         <= 1'b0;
    end else begin
      if (br_taken) begin
        // Every response still in flight is stale; outstanding already counts
        // any earlier stale ones, so this also covers back-to-back redirects.
        pc          <= br_target;
        resp_pc     <= br_target;
        first_flag  <= 1'b1;
        drop_cnt    <= outstanding - CNT_W'(resp);
        outstanding <= outstanding - CNT_W'(resp);
      end else begin
        if (issue) pc <= pc + 32'd1;
        if (accept) begin
          resp_pc    <= resp_pc + 32'd1;
          first_flag <= 1'b0;
        end
        if (resp && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
        outstanding <= outstanding + CNT_W'(issue) - CNT_W'(resp);
      end
      if (imem_rvalid && (outstanding == '0)) err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mips32_fetch_queue.sv
// Bench for mips32_fetch_queue: directed vector table, hand-written redirect,
// halt, stray-response and reset sequences, then randomized traffic vs a queue model.
module tb_mips32_fetch_queue;

  localparam int DEPTH = 4;

  logic        clk1 = 1'b0;
  logic        rst;
  logic        halted;
  logic        br_taken;
  logic [31:0] br_target;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_ir;
  logic [31:0] id_npc;
  logic        id_taken;
  logic        err;

  mips32_fetch_queue #(.DEPTH(DEPTH), .RESET_PC(32'h0)) dut (
    .clk1        (clk1),
    .rst         (rst),
    .halted      (halted),
    .br_taken    (br_taken),
    .br_target   (br_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .id_valid    (id_valid),
    .id_ready    (id_ready),
    .id_ir       (id_ir),
    .id_npc      (id_npc),
    .id_taken    (id_taken),
    .err         (err)
  );

  always #5 clk1 = ~clk1;

  int errors = 0;
  int checks = 0;

  // Reference model: fetches in flight (address + stale tag) and delivered words.
  typedef struct { logic [31:0] addr; bit stale; } req_t;
  typedef struct { logic [31:0] ir; logic [31:0] npc; bit taken; } ent_t;
  req_t        infl[$];
  ent_t        outq[$];
  logic [31:0] m_pc;
  bit          m_taken;
  bit          m_err;

  typedef struct {
    logic g; logic rv; logic [31:0] rsp; logic rdy;
    logic ereq; logic [31:0] eaddr; logic evalid; logic [31:0] enpc;
  } vec_t;
  vec_t tbl[14];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h0BAD_F00D;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic idle_inputs();
    halted = 0; br_taken = 0; br_target = 0; imem_gnt = 0;
    imem_rvalid = 0; imem_rdata = 0; id_ready = 0;
  endtask

  task automatic model_clear();
    infl.delete(); outq.delete();
    m_pc = 32'h0; m_taken = 0; m_err = 0;
  endtask

  task automatic check_zero_outputs(input string tag);
    chk({tag, "_req"},   {31'b0, imem_req}, 32'h0);
    chk({tag, "_addr"},  imem_addr, 32'h0);
    chk({tag, "_valid"}, {31'b0, id_valid}, 32'h0);
    chk({tag, "_ir"},    id_ir, 32'h0);
    chk({tag, "_npc"},   id_npc, 32'h0);
    chk({tag, "_taken"}, {31'b0, id_taken}, 32'h0);
    chk({tag, "_err"},   {31'b0, err}, 32'h0);
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1;
    @(posedge clk1); #1;
    check_zero_outputs("reset");
    @(posedge clk1); #1;
    rst = 0;
    model_clear();
  endtask

  // One clock cycle: drive, compare against the model, advance the model.
  task automatic step(input bit g, input bit rv, input bit rdy, input bit hlt,
                      input bit br, input logic [31:0] tgt);
    bit   ereq;
    bit   do_pop;
    req_t r;
    ent_t e;
    @(posedge clk1); #1;
    imem_gnt    = g;
    imem_rvalid = rv;
    imem_rdata  = (infl.size() > 0) ? mem_word(infl[0].addr) : 32'hDEAD_BEEF;
    id_ready    = rdy;
    halted      = hlt;
    br_taken    = br;
    br_target   = tgt;
    #3;
    ereq = !hlt && !br && ((outq.size() + infl.size()) < DEPTH);
    chk("m_req",   {31'b0, imem_req}, {31'b0, ereq});
    chk("m_addr",  imem_addr, m_pc);
    chk("m_valid", {31'b0, id_valid}, {31'b0, outq.size() > 0});
    chk("m_err",   {31'b0, err}, {31'b0, m_err});
    if (outq.size() > 0) begin
      chk("m_ir",    id_ir, outq[0].ir);
      chk("m_npc",   id_npc, outq[0].npc);
      chk("m_taken", {31'b0, id_taken}, {31'b0, outq[0].taken});
    end
    do_pop = rdy && (outq.size() > 0) && !br;
    if (do_pop) outq.delete(0);
    if (rv) begin
      if (infl.size() == 0) m_err = 1;
      else begin
        r = infl.pop_front();
        if (!r.stale && !br) begin
          e.ir = mem_word(r.addr); e.npc = r.addr + 32'd1; e.taken = m_taken;
          outq.push_back(e);
          m_taken = 0;
        end
      end
    end
    if (br) begin
      outq.delete();
      foreach (infl[i]) infl[i].stale = 1;
      m_pc = tgt;
      m_taken = 1;
    end
    if (ereq && g) begin
      r.addr = m_pc; r.stale = 0;
      infl.push_back(r);
      m_pc = m_pc + 32'd1;
    end
  endtask

  initial begin
    bit          hlt_r;
    bit          rv_r;
    bit          br_r;
    logic [31:0] tgt_r;

    // Straight-line fetch with rvalid one cycle after gnt; decode stalls, then drains.
    tbl[0]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd0, 1'b0, 32'd0};
    tbl[1]  = '{1'b1, 1'b1, 32'd0, 1'b0, 1'b1, 32'd1, 1'b0, 32'd0};
    tbl[2]  = '{1'b1, 1'b1, 32'd1, 1'b0, 1'b1, 32'd2, 1'b1, 32'd1};
    tbl[3]  = '{1'b1, 1'b1, 32'd2, 1'b0, 1'b1, 32'd3, 1'b1, 32'd1};
    tbl[4]  = '{1'b1, 1'b1, 32'd3, 1'b0, 1'b0, 32'd4, 1'b1, 32'd1};
    tbl[5]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd4, 1'b1, 32'd1};
    tbl[6]  = '{1'b1, 1'b0, 32'd0, 1'b1, 1'b0, 32'd4, 1'b1, 32'd1};
    tbl[7]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 32'd4, 1'b1, 32'd2};
    tbl[8]  = '{1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 32'd5, 1'b1, 32'd2};
    tbl[9]  = '{1'b0, 1'b1, 32'd4, 1'b1, 1'b0, 32'd5, 1'b1, 32'd2};
    tbl[10] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd5, 1'b1, 32'd3};
    tbl[11] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd5, 1'b1, 32'd4};
    tbl[12] = '{1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 32'd5, 1'b1, 32'd5};
    tbl[13] = '{1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 32'd5, 1'b0, 32'd0};

    do_reset();
    for (int i = 0; i < 14; i++) begin
      @(posedge clk1); #1;
      imem_gnt    = tbl[i].g;
      imem_rvalid = tbl[i].rv;
      imem_rdata  = mem_word(tbl[i].rsp);
      id_ready    = tbl[i].rdy;
      #3;
      chk($sformatf("tbl%0d_req", i),   {31'b0, imem_req}, {31'b0, tbl[i].ereq});
      chk($sformatf("tbl%0d_addr", i),  imem_addr, tbl[i].eaddr);
      chk($sformatf("tbl%0d_valid", i), {31'b0, id_valid}, {31'b0, tbl[i].evalid});
      if (tbl[i].evalid) begin
        chk($sformatf("tbl%0d_npc", i),   id_npc, tbl[i].enpc);
        chk($sformatf("tbl%0d_ir", i),    id_ir, mem_word(tbl[i].enpc - 32'd1));
        chk($sformatf("tbl%0d_taken", i), {31'b0, id_taken}, 32'h0);
      end
    end

    // Redirect with one entry queued and two fetches in flight.
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 1, 32'h40);
    step(1, 1, 0, 0, 0, 0);
    chk("br_flush_empty", {31'b0, id_valid}, 32'h0);
    step(1, 1, 0, 0, 0, 0);
    chk("br_drop_empty", {31'b0, id_valid}, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 0, 0, 0);
    chk("br_first_ir", id_ir, mem_word(32'h40));
    chk("br_first_npc", id_npc, 32'h41);
    chk("br_first_taken", {31'b0, id_taken}, 32'h1);
    step(0, 0, 1, 0, 0, 0);
    chk("br_second_npc", id_npc, 32'h42);
    chk("br_second_taken", {31'b0, id_taken}, 32'h0);

    // Redirect coinciding with a response while another is still in flight.
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, 0, 0, 1, 32'h100);
    step(0, 1, 0, 0, 0, 0);
    chk("brrv_drop1", {31'b0, id_valid}, 32'h0);
    step(1, 0, 0, 0, 0, 0);
    chk("brrv_drop2", {31'b0, id_valid}, 32'h0);
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 1, 0, 0, 0);
    chk("brrv_npc", id_npc, 32'h101);
    chk("brrv_taken", {31'b0, id_taken}, 32'h1);

    // Halt with two in flight: drained in order, redirect moves pc only.
    do_reset();
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    chk("halt_noreq", {31'b0, imem_req}, 32'h0);
    step(1, 1, 0, 1, 0, 0);
    step(1, 1, 1, 1, 0, 0);
    chk("halt_npc1", id_npc, 32'h1);
    step(1, 0, 1, 1, 0, 0);
    chk("halt_npc2", id_npc, 32'h2);
    step(1, 0, 0, 1, 1, 32'h200);
    step(1, 0, 0, 1, 0, 0);
    chk("halt_br_addr", imem_addr, 32'h200);
    chk("halt_br_noreq", {31'b0, imem_req}, 32'h0);

    // PC wrap at the top of the address space.
    step(0, 0, 0, 0, 1, 32'hFFFF_FFFF);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    chk("wrap_addr", imem_addr, 32'h0);
    step(0, 1, 1, 0, 0, 0);
    chk("wrap_npc", id_npc, 32'h0);

    // Stray response, then asynchronous reset in the middle of traffic.
    do_reset();
    step(0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    chk("stray_err", {31'b0, err}, 32'h1);
    chk("stray_nopush", {31'b0, id_valid}, 32'h0);
    step(1, 0, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    step(1, 1, 0, 0, 0, 0);
    @(negedge clk1);
    idle_inputs();
    rst = 1;
    #1;
    check_zero_outputs("async_rst");
    @(posedge clk1); #1;
    rst = 0;
    model_clear();

    // Randomized traffic against the model.
    hlt_r = 0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 49) == 0) hlt_r = !hlt_r;
      rv_r  = (infl.size() > 0) && ($urandom_range(0, 2) != 0);
      br_r  = ($urandom_range(0, 24) == 0);
      tgt_r = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFFC + 32'($urandom_range(0, 3))) : $urandom;
      step($urandom_range(0, 3) != 0, rv_r, $urandom_range(0, 3) != 0, hlt_r, br_r, tgt_r);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
